targ_fb_queue: RTL and testbench

Collects resolved-branch target outcomes from all execute pipes and serializes them into the single feedback port of the branch target predictor. The queue sits between the execute/resolve stages and `targ_pred`. It filters out outcomes that need no BTB update and buffers the rest in a FIFO. It drains at most one update per cycle and asserts backpressure when it cannot absorb a full cycle of resolutions.

---
 rtl/targ_fb_queue_pkg.sv | 33 +++
 rtl/targ_fb_queue_sel.sv | 79 +++++++
 rtl/targ_fb_queue.sv | 130 +++++++++++++
 tb/tb_targ_fb_queue.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/targ_fb_queue_pkg.sv
// Shared types for the branch-target feedback path.
// sys: machine address type. core: resolve-stage record and targ_pred feedback record.
package sys;
  typedef logic [31:0] addr_t;
endpackage

package core;
  typedef struct packed {
    logic       valid;
    logic       taken;
    logic       pred_hit;
    sys::addr_t addr;
    sys::addr_t pred_targ;
    sys::addr_t targ;
  } targ_res_t;

  localparam targ_res_t targ_res_rst = '{valid: 1'b0, taken: 1'b0, pred_hit: 1'b0,
                                         addr: 32'h0, pred_targ: 32'h0, targ: 32'h0};

  typedef struct packed {
    logic       valid;
    sys::addr_t addr;
    sys::addr_t targ;
  } targ_pred_fb_t;

  localparam targ_pred_fb_t targ_pred_fb_rst = '{valid: 1'b0, addr: 32'h0, targ: 32'h0};

  // A resolution needs a BTB update only when the branch was taken and the
  // predictor either missed or supplied the wrong target.
  function automatic logic targ_qualifies(targ_res_t r);
    return r.valid && r.taken && (!r.pred_hit || (r.pred_targ != r.targ));
  endfunction
endpackage

// File: rtl/targ_fb_queue_sel.sv
// targ_fb_sel: qualifies the per-pipe resolutions and compacts the ones that
// need a slot into a dense write vector (oldest first), limited by free space.
// With TARG_FB_COALESCE_EN defined it also folds same-address inputs together
// and redirects inputs that hit a queued entry into an in-place target update.
module targ_fb_sel
  import core::*;
#(
  parameter  int s_pipe_cnt = 3,
  parameter  int depth      = 8,
  localparam int cnt_width  = $clog2(depth) + 1
) (
  input  targ_res_t            res_i [s_pipe_cnt],
  input  logic [cnt_width-1:0] free_i,
`ifdef TARG_FB_COALESCE_EN
  input  logic [depth-1:0]     match_ok_i,
  input  sys::addr_t           q_addr_i [depth],
  output logic [depth-1:0]     upd_vld_o,
  output sys::addr_t           upd_targ_o [depth],
`endif
  output targ_pred_fb_t        wr_ent_o [s_pipe_cnt],
  output logic [cnt_width-1:0] acc_cnt_o,
  output logic                 drop_o
);

  // Walk the pipes in index order, placing each slot-needing input at the next free write position
  always_comb begin
    int   acc;
    logic need;
`ifdef TARG_FB_COALESCE_EN
    logic hit;
    hit = 1'b0;
    upd_vld_o = {depth{1'b0}};
    for (int k = 0; k < depth; k++) begin
      upd_targ_o[k] = 32'h0;
    end
`endif
    acc    = 0;
    need   = 1'b0;
    drop_o = 1'b0;
    for (int j = 0; j < s_pipe_cnt; j++) begin
      wr_ent_o[j] = targ_pred_fb_rst;
    end
    for (int i = 0; i < s_pipe_cnt; i++) begin
      need = targ_qualifies(res_i[i]);
`ifdef TARG_FB_COALESCE_EN
      // A younger same-cycle input to the same address supersedes this one.
      for (int j = i + 1; j < s_pipe_cnt; j++) begin
        if (targ_qualifies(res_i[j]) && (res_i[j].addr == res_i[i].addr)) begin
          need = 1'b0;
        end
      end
      // A surviving input that hits a queued entry rewrites it in place.
      hit = 1'b0;
      for (int k = 0; k < depth; k++) begin
        if (need && match_ok_i[k] && (q_addr_i[k] == res_i[i].addr)) begin
          upd_vld_o[k]  = 1'b1;
          upd_targ_o[k] = res_i[i].targ;
          hit           = 1'b1;
        end
      end
      need = need && !hit;
`endif
      if (need && (acc < int'(free_i))) begin
        for (int j = 0; j < s_pipe_cnt; j++) begin
          if (j == acc) begin
            wr_ent_o[j] = '{valid: 1'b1, addr: res_i[i].addr, targ: res_i[i].targ};
          end
        end
        acc = acc + 1;
      end else if (need) begin
        drop_o = 1'b1;
      end else begin
        acc = acc;
      end
    end
    acc_cnt_o = cnt_width'(acc);
  end

endmodule

// File: rtl/targ_fb_queue.sv
// targ_fb_queue: buffers BTB updates from all execute pipes and drains one per
// cycle into the registered feedback port of targ_pred.
// Optional feature macro: TARG_FB_COALESCE_EN (in-place coalescing by address).
module targ_fb_queue
  import core::*;
#(
  parameter  int s_pipe_cnt = 3,
  parameter  int depth      = 8,
  localparam int cnt_width  = $clog2(depth) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  targ_res_t     res [s_pipe_cnt],
  output targ_pred_fb_t fb,
  output logic          stall,
  output logic          ovf
);

  localparam int ptr_width = $clog2(depth);

  sys::addr_t           mem_addr_q [depth];
  sys::addr_t           mem_targ_q [depth];
  logic [ptr_width-1:0] head_q, head_d;
  logic [ptr_width-1:0] tail_q, tail_d;
  logic [cnt_width-1:0] count_q, count_d;
  targ_pred_fb_t        fb_q, fb_d;
  logic                 ovf_q, ovf_d;

  logic [cnt_width-1:0] free_s;
  logic [cnt_width-1:0] acc_cnt_s;
  logic                 deq_s;
  logic                 drop_s;
  targ_pred_fb_t        wr_ent_s [s_pipe_cnt];
  logic [ptr_width-1:0] wr_idx_s [s_pipe_cnt];

`ifdef TARG_FB_COALESCE_EN
  logic [depth-1:0]     match_ok_s;
  logic [depth-1:0]     upd_vld_s;
  sys::addr_t           upd_targ_s [depth];
`endif

  // Free space comes from registered count only: a same-cycle dequeue earns no credit.
  assign free_s = cnt_width'(depth) - count_q;
  assign deq_s  = en && (count_q != cnt_width'(0));
  assign stall  = free_s < cnt_width'(s_pipe_cnt);
  assign fb     = fb_q;
  assign ovf    = ovf_q;

`ifdef TARG_FB_COALESCE_EN
  // Mark occupied entries as overwrite candidates, except the head leaving this cycle
  always_comb begin
    logic [ptr_width-1:0] occ_off;
    occ_off = ptr_width'(0);
    for (int k = 0; k < depth; k++) begin
      occ_off       = ptr_width'(k) - head_q;
      match_ok_s[k] = (cnt_width'(occ_off) < count_q) &&
                      !(deq_s && (ptr_width'(k) == head_q));
    end
  end
`endif

  targ_fb_sel #(
    .s_pipe_cnt (s_pipe_cnt),
    .depth      (depth)
  ) u_sel (
    .res_i      (res),
    .free_i     (free_s),
`ifdef TARG_FB_COALESCE_EN
    .match_ok_i (match_ok_s),
    .q_addr_i   (mem_addr_q),
    .upd_vld_o  (upd_vld_s),
    .upd_targ_o (upd_targ_s),
`endif
    .wr_ent_o   (wr_ent_s),
    .acc_cnt_o  (acc_cnt_s),
    .drop_o     (drop_s)
  );

  // Next-state for pointers, occupancy, overflow flag and the feedback register
  always_comb begin
    for (int j = 0; j < s_pipe_cnt; j++) begin
      wr_idx_s[j] = tail_q + ptr_width'(j);
    end
    tail_d  = tail_q + ptr_width'(acc_cnt_s);
    head_d  = head_q + ptr_width'(deq_s);
    count_d = count_q + acc_cnt_s - cnt_width'(deq_s);
    ovf_d   = ovf_q | drop_s;
    if (deq_s) begin
      fb_d = '{valid: 1'b1, addr: mem_addr_q[head_q], targ: mem_targ_q[head_q]};
    end else begin
      fb_d = '{valid: 1'b0, addr: fb_q.addr, targ: fb_q.targ};
    end
  end

  // State registers and FIFO storage; reset discards every queued entry
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= ptr_width'(0);
      tail_q  <= ptr_width'(0);
      count_q <= cnt_width'(0);
      fb_q    <= targ_pred_fb_rst;
      ovf_q   <= 1'b0;
      for (int k = 0; k < depth; k++) begin
        mem_addr_q[k] <= 32'h0;
        mem_targ_q[k] <= 32'h0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      fb_q    <= fb_d;
      ovf_q   <= ovf_d;
      for (int j = 0; j < s_pipe_cnt; j++) begin
        if (wr_ent_s[j].valid) begin
          mem_addr_q[wr_idx_s[j]] <= wr_ent_s[j].addr;
          mem_targ_q[wr_idx_s[j]] <= wr_ent_s[j].targ;
        end
      end
`ifdef TARG_FB_COALESCE_EN
      for (int k = 0; k < depth; k++) begin
        if (upd_vld_s[k]) begin
          mem_targ_q[k] <= upd_targ_s[k];
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_targ_fb_queue.sv
// Directed, table-driven bench for targ_fb_queue plus a hand-written
// fill/no-credit/drain sequence.
`timescale 1ns/1ps
module tb_targ_fb_queue;
  import core::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  targ_res_t     res [3];
  targ_pred_fb_t fb;
  logic          stall;
  logic          ovf;

  always #5 clk = ~clk;

  targ_fb_queue #(.s_pipe_cnt(3), .depth(8)) dut (
    .clk(clk), .rst(rst), .en(en), .res(res), .fb(fb), .stall(stall), .ovf(ovf)
  );

  typedef struct {
    logic       rst;
    logic       en;
    targ_res_t  r0, r1, r2;
    logic       ev;
    sys::addr_t ea, et;
    logic       es, eo;
  } vec_t;

  vec_t vecs[$];
  int applied = 0;
  int miscompares = 0;

  localparam targ_res_t NONE = targ_res_rst;

  function automatic targ_res_t mis(sys::addr_t a, sys::addr_t t);
    return '{valid: 1'b1, taken: 1'b1, pred_hit: 1'b0, addr: a, pred_targ: 32'h0, targ: t};
  endfunction
  function automatic targ_res_t ntk(sys::addr_t a, sys::addr_t t);
    return '{valid: 1'b1, taken: 1'b0, pred_hit: 1'b0, addr: a, pred_targ: 32'h0, targ: t};
  endfunction
  function automatic targ_res_t hitok(sys::addr_t a, sys::addr_t t);
    return '{valid: 1'b1, taken: 1'b1, pred_hit: 1'b1, addr: a, pred_targ: t, targ: t};
  endfunction
  function automatic targ_res_t hitbad(sys::addr_t a, sys::addr_t t);
    return '{valid: 1'b1, taken: 1'b1, pred_hit: 1'b1, addr: a, pred_targ: t + 32'h1, targ: t};
  endfunction

  task automatic add(input logic r, input logic e, input targ_res_t a, input targ_res_t b,
                     input targ_res_t c, input logic ev, input sys::addr_t ea,
                     input sys::addr_t et, input logic es, input logic eo);
    vec_t v;
    v.rst = r; v.en = e; v.r0 = a; v.r1 = b; v.r2 = c;
    v.ev = ev; v.ea = ea; v.et = et; v.es = es; v.eo = eo;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [66:0] got, input logic [66:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0;
    for (int p = 0; p < 3; p++) res[p] = NONE;

    // reset, single update latency
    add(1'b1, 1'b1, NONE, NONE, NONE,                      1'b0, 32'h0,   32'h0,   1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, mis(32'h100, 32'h200), NONE,     1'b0, 32'h0,   32'h0,   1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b0, 32'h100, 32'h200, 1'b0, 1'b0);
    // three pipes, middle not taken
    add(1'b0, 1'b1, mis(32'h10, 32'h11), ntk(32'h20, 32'h21), mis(32'h30, 32'h31),
                                                           1'b0, 32'h100, 32'h200, 1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'h10,  32'h11,  1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'h30,  32'h31,  1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b0, 32'h30,  32'h31,  1'b0, 1'b0);
    // correctly predicted: nothing queued; then a hit with wrong target
    add(1'b0, 1'b1, hitok(32'h400, 32'h400), NONE, NONE,   1'b0, 32'h30,  32'h31,  1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, hitbad(32'h500, 32'h501),  1'b0, 32'h30,  32'h31,  1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'h500, 32'h501, 1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b0, 32'h500, 32'h501, 1'b0, 1'b0);
    // fill with en=0, stall from count 6, ninth input overflows
    add(1'b0, 1'b0, mis(32'hA0, 32'hB0), mis(32'hA1, 32'hB1), mis(32'hA2, 32'hB2),
                                                           1'b0, 32'h500, 32'h501, 1'b0, 1'b0);
    add(1'b0, 1'b0, mis(32'hA3, 32'hB3), mis(32'hA4, 32'hB4), mis(32'hA5, 32'hB5),
                                                           1'b0, 32'h500, 32'h501, 1'b1, 1'b0);
    add(1'b0, 1'b0, mis(32'hA6, 32'hB6), mis(32'hA7, 32'hB7), NONE,
                                                           1'b0, 32'h500, 32'h501, 1'b1, 1'b0);
    add(1'b0, 1'b0, mis(32'hA8, 32'hB8), NONE, NONE,       1'b0, 32'h500, 32'h501, 1'b1, 1'b1);
    // drain exactly eight in order
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'hA0,  32'hB0,  1'b1, 1'b1);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'hA1,  32'hB1,  1'b1, 1'b1);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'hA2,  32'hB2,  1'b0, 1'b1);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'hA3,  32'hB3,  1'b0, 1'b1);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'hA4,  32'hB4,  1'b0, 1'b1);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'hA5,  32'hB5,  1'b0, 1'b1);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'hA6,  32'hB6,  1'b0, 1'b1);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'hA7,  32'hB7,  1'b0, 1'b1);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b0, 32'hA7,  32'hB7,  1'b0, 1'b1);
    // reset with five entries queued
    add(1'b0, 1'b0, mis(32'hD0, 32'hE0), mis(32'hD1, 32'hE1), mis(32'hD2, 32'hE2),
                                                           1'b0, 32'hA7,  32'hB7,  1'b0, 1'b1);
    add(1'b0, 1'b0, mis(32'hD3, 32'hE3), mis(32'hD4, 32'hE4), NONE,
                                                           1'b0, 32'hA7,  32'hB7,  1'b0, 1'b1);
    add(1'b1, 1'b1, NONE, NONE, NONE,                      1'b0, 32'h0,   32'h0,   1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b0, 32'h0,   32'h0,   1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b0, 32'h0,   32'h0,   1'b0, 1'b0);
    // duplicate addresses across cycles and within one cycle
    add(1'b0, 1'b0, mis(32'h80, 32'h1), NONE, NONE,        1'b0, 32'h0,   32'h0,   1'b0, 1'b0);
    add(1'b0, 1'b0, mis(32'h80, 32'h2), NONE, NONE,        1'b0, 32'h0,   32'h0,   1'b0, 1'b0);
`ifdef TARG_FB_COALESCE_EN
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'h80,  32'h2,   1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b0, 32'h80,  32'h2,   1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b0, 32'h80,  32'h2,   1'b0, 1'b0);
    add(1'b0, 1'b0, mis(32'h90, 32'h5), NONE, mis(32'h90, 32'h6),
                                                           1'b0, 32'h80,  32'h2,   1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'h90,  32'h6,   1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b0, 32'h90,  32'h6,   1'b0, 1'b0);
`else
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'h80,  32'h1,   1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'h80,  32'h2,   1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b0, 32'h80,  32'h2,   1'b0, 1'b0);
    add(1'b0, 1'b0, mis(32'h90, 32'h5), NONE, mis(32'h90, 32'h6),
                                                           1'b0, 32'h80,  32'h2,   1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'h90,  32'h5,   1'b0, 1'b0);
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b1, 32'h90,  32'h6,   1'b0, 1'b0);
`endif
    add(1'b0, 1'b1, NONE, NONE, NONE,                      1'b0, 32'h90,  32'h6,   1'b0, 1'b0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en;
      res[0] = vecs[i].r0; res[1] = vecs[i].r1; res[2] = vecs[i].r2;
      step();
      check($sformatf("vec%0d", i), {fb, stall, ovf},
            {vecs[i].ev, vecs[i].ea, vecs[i].et, vecs[i].es, vecs[i].eo});
    end

    // Hand sequence: fill past capacity, then no dequeue credit on the draining edge.
    rst = 1'b1; en = 1'b0;
    for (int p = 0; p < 3; p++) res[p] = NONE;
    step();
    check("seq_reset", {fb, stall, ovf}, {1'b0, 32'h0, 32'h0, 1'b0, 1'b0});
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 3; p++) res[p] = mis(32'hE0 + 32'(3 * c + p), 32'h1E0 + 32'(3 * c + p));
      step();
      if (c == 1) check("seq_stall6", {stall, ovf}, {1'b1, 1'b0});
    end
    check("seq_ovf9", {fb.valid, stall, ovf}, {1'b0, 1'b1, 1'b1});
    en = 1'b1;
    for (int p = 0; p < 3; p++) res[p] = mis(32'hF0 + 32'(p), 32'h1F0 + 32'(p));
    step();
    for (int p = 0; p < 3; p++) res[p] = NONE;
    n = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (fb.valid) begin
        check($sformatf("seq_drain%0d", n), {fb.addr, fb.targ},
              {32'hE0 + 32'(n), 32'h1E0 + 32'(n)});
        n++;
      end
      step();
    end
    applied++;
    if (n != 8) begin
      miscompares++;
      $display("FAIL seq_drain_count: got %0d entries expected 8", n);
    end
    check("seq_end", {fb.valid, stall, ovf}, {1'b0, 1'b0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
